// File: rtl/comm_tx_scheduler.sv
// Link transmit scheduler: queues ack/new-game/miss/ball messages, feeds them one at a time
// to the serial sender, and runs new-game retransmission until the peer acknowledges.
module comm_tx_scheduler #(
  parameter int unsigned RETRY_CYCLES = 5000000,
  parameter int unsigned MAX_RETRIES  = 10,
  parameter int unsigned DROP_W       = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              ball_req,
  input  logic [8:0]        ball_y_in,
  input  logic [3:0]        vel_x_in,
  input  logic [3:0]        vel_y_in,
  input  logic              miss_req,
  input  logic [4:0]        my_score_in,
  input  logic [4:0]        your_score_in,
  input  logic              you_serve_in,
  input  logic              new_game_req,
  input  logic              you_serve_first_in,
  input  logic              new_game_ack_req,
  input  logic              new_game_ack_rx,
  input  logic              message_sent,
  output logic              send_new_message,
  output logic              ball_message_tx,
  output logic              miss_message_tx,
  output logic              new_game_message_tx,
  output logic              new_game_ack_message_tx,
  output logic [8:0]        ball_y_tx,
  output logic [3:0]        velocity_x_tx,
  output logic [3:0]        velocity_y_tx,
  output logic [4:0]        my_score_tx,
  output logic [4:0]        your_score_tx,
  output logic              you_should_serve_tx,
  output logic              you_serve_first_tx,
  output logic              link_ready,
  output logic              link_fail,
  output logic [DROP_W-1:0] dropped_count
);

  typedef enum logic [1:0] {StIdle, StSend, StAwaitAck} state_e;

  localparam logic [3:0] TyAck  = 4'b1000;
  localparam logic [3:0] TyNg   = 4'b0100;
  localparam logic [3:0] TyMiss = 4'b0010;
  localparam logic [3:0] TyBall = 4'b0001;

  state_e            state_q, state_d;
  logic [3:0]        type_q, type_d;
  logic              from_await_q, from_await_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       retry_q, retry_d;
  logic              link_ready_q, link_ready_d;
  logic              link_fail_q, link_fail_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // Pending slots
  logic              ack_v_q, ack_v_d;
  logic              ng_v_q, ng_v_d;
  logic              ng_ysf_q, ng_ysf_d;
  logic              miss_v_q, miss_v_d;
  logic [4:0]        miss_my_q, miss_my_d;
  logic [4:0]        miss_your_q, miss_your_d;
  logic              miss_ys_q, miss_ys_d;
  logic              ball_v_q, ball_v_d;
  logic [8:0]        ball_y_q, ball_y_d;
  logic [3:0]        ball_vx_q, ball_vx_d;
  logic [3:0]        ball_vy_q, ball_vy_d;

  // Output payload registers
  logic [8:0]        y_tx_q, y_tx_d;
  logic [3:0]        vx_tx_q, vx_tx_d;
  logic [3:0]        vy_tx_q, vy_tx_d;
  logic [4:0]        my_tx_q, my_tx_d;
  logic [4:0]        your_tx_q, your_tx_d;
  logic              ys_tx_q, ys_tx_d;
  logic              ysf_tx_q, ysf_tx_d;

  logic grant_ack, grant_ng, grant_miss, grant_ball, resend_ng;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    from_await_d = from_await_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    link_ready_d = link_ready_q;
    link_fail_d  = link_fail_q;
    drop_d       = drop_q;
    ack_v_d      = ack_v_q;
    ng_v_d       = ng_v_q;
    ng_ysf_d     = ng_ysf_q;
    miss_v_d     = miss_v_q;
    miss_my_d    = miss_my_q;
    miss_your_d  = miss_your_q;
    miss_ys_d    = miss_ys_q;
    ball_v_d     = ball_v_q;
    ball_y_d     = ball_y_q;
    ball_vx_d    = ball_vx_q;
    ball_vy_d    = ball_vy_q;
    y_tx_d       = y_tx_q;
    vx_tx_d      = vx_tx_q;
    vy_tx_d      = vy_tx_q;
    my_tx_d      = my_tx_q;
    your_tx_d    = your_tx_q;
    ys_tx_d      = ys_tx_q;
    ysf_tx_d     = ysf_tx_q;
    grant_ack    = 1'b0;
    grant_ng     = 1'b0;
    grant_miss   = 1'b0;
    grant_ball   = 1'b0;
    resend_ng    = 1'b0;

    // A fresh new-game abandons the current handshake; no grant on that edge.
    if (state_q == StAwaitAck && new_game_req) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ack_v_q) begin
            grant_ack = 1'b1;
          end else if (ng_v_q) begin
            grant_ng = 1'b1;
          end else if (link_ready_q && miss_v_q) begin
            grant_miss = 1'b1;
          end else if (link_ready_q && ball_v_q) begin
            grant_ball = 1'b1;
          end
          if (grant_ack || grant_ng || grant_miss || grant_ball) begin
            state_d      = StSend;
            from_await_d = 1'b0;
          end
        end
        StSend: begin
          if (message_sent) begin
            if (type_q == TyNg) begin
              state_d = StAwaitAck;
              timer_d = '0;
            end else if (type_q == TyAck && from_await_q) begin
              state_d = StAwaitAck;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StAwaitAck: begin
          if (new_game_ack_rx) begin
            link_ready_d = 1'b1;
            state_d      = StIdle;
          end else if (ack_v_q) begin
            grant_ack    = 1'b1;
            from_await_d = 1'b1;
            state_d      = StSend;
          end else if (timer_q == RETRY_CYCLES - 1) begin
            if (retry_q < MAX_RETRIES) begin
              retry_d      = retry_q + 32'd1;
              resend_ng    = 1'b1;
              from_await_d = 1'b0;
              state_d      = StSend;
            end else begin
              link_fail_d = 1'b1;
              state_d     = StIdle;
            end
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (grant_ack) begin
      ack_v_d = 1'b0;
      type_d  = TyAck;
    end
    if (grant_ng || resend_ng) begin
      type_d   = TyNg;
      ysf_tx_d = ng_ysf_q;
    end
    if (grant_ng) ng_v_d = 1'b0;
    if (grant_miss) begin
      miss_v_d  = 1'b0;
      type_d    = TyMiss;
      my_tx_d   = miss_my_q;
      your_tx_d = miss_your_q;
      ys_tx_d   = miss_ys_q;
    end
    if (grant_ball) begin
      ball_v_d = 1'b0;
      type_d   = TyBall;
      y_tx_d   = ball_y_q;
      vx_tx_d  = ball_vx_q;
      vy_tx_d  = ball_vy_q;
    end

    if (new_game_req) begin
      link_ready_d = 1'b0;
      link_fail_d  = 1'b0;
      retry_d      = '0;
      ball_v_d     = 1'b0;
      miss_v_d     = 1'b0;
    end

    // Requests are applied last so a same-edge set beats a grant or clear.
    if (new_game_ack_req) ack_v_d = 1'b1;
    if (new_game_req) begin
      ng_v_d   = 1'b1;
      ng_ysf_d = you_serve_first_in;
    end
    if (miss_req) begin
      miss_v_d    = 1'b1;
      miss_my_d   = my_score_in;
      miss_your_d = your_score_in;
      miss_ys_d   = you_serve_in;
    end
    if (ball_req) begin
      if (ball_v_q && !grant_ball && !new_game_req && drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
      ball_v_d  = 1'b1;
      ball_y_d  = ball_y_in;
      ball_vx_d = vel_x_in;
      ball_vy_d = vel_y_in;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      type_q       <= '0;
      from_await_q <= 1'b0;
      timer_q      <= '0;
      retry_q      <= '0;
      link_ready_q <= 1'b0;
      link_fail_q  <= 1'b0;
      drop_q       <= '0;
      ack_v_q      <= 1'b0;
      ng_v_q       <= 1'b0;
      ng_ysf_q     <= 1'b0;
      miss_v_q     <= 1'b0;
      miss_my_q    <= '0;
      miss_your_q  <= '0;
      miss_ys_q    <= 1'b0;
      ball_v_q     <= 1'b0;
      ball_y_q     <= '0;
      ball_vx_q    <= '0;
      ball_vy_q    <= '0;
      y_tx_q       <= '0;
      vx_tx_q      <= '0;
      vy_tx_q      <= '0;
      my_tx_q      <= '0;
      your_tx_q    <= '0;
      ys_tx_q      <= 1'b0;
      ysf_tx_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      from_await_q <= from_await_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      link_ready_q <= link_ready_d;
      link_fail_q  <= link_fail_d;
      drop_q       <= drop_d;
      ack_v_q      <= ack_v_d;
      ng_v_q       <= ng_v_d;
      ng_ysf_q     <= ng_ysf_d;
      miss_v_q     <= miss_v_d;
      miss_my_q    <= miss_my_d;
      miss_your_q  <= miss_your_d;
      miss_ys_q    <= miss_ys_d;
      ball_v_q     <= ball_v_d;
      ball_y_q     <= ball_y_d;
      ball_vx_q    <= ball_vx_d;
      ball_vy_q    <= ball_vy_d;
      y_tx_q       <= y_tx_d;
      vx_tx_q      <= vx_tx_d;
      vy_tx_q      <= vy_tx_d;
      my_tx_q      <= my_tx_d;
      your_tx_q    <= your_tx_d;
      ys_tx_q      <= ys_tx_d;
      ysf_tx_q     <= ysf_tx_d;
    end
  end

  assign send_new_message        = (state_q == StSend);
  assign new_game_ack_message_tx = send_new_message & type_q[3];
  assign new_game_message_tx     = send_new_message & type_q[2];
  assign miss_message_tx         = send_new_message & type_q[1];
  assign ball_message_tx         = send_new_message & type_q[0];
  assign ball_y_tx               = y_tx_q;
  assign velocity_x_tx           = vx_tx_q;
  assign velocity_y_tx           = vy_tx_q;
  assign my_score_tx             = my_tx_q;
  assign your_score_tx           = your_tx_q;
  assign you_should_serve_tx     = ys_tx_q;
  assign you_serve_first_tx      = ysf_tx_q;
  assign link_ready              = link_ready_q;
  assign link_fail               = link_fail_q;
  assign dropped_count           = drop_q;

endmodule

// File: tb/tb_comm_tx_scheduler.sv
// Self-checking bench for comm_tx_scheduler: vector table plus scoreboard of expected sends.
module tb_comm_tx_scheduler;

  localparam logic [3:0] TAck  = 4'b1000;
  localparam logic [3:0] TNg   = 4'b0100;
  localparam logic [3:0] TMiss = 4'b0010;
  localparam logic [3:0] TBall = 4'b0001;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       ball_req, miss_req, new_game_req, new_game_ack_req, new_game_ack_rx, message_sent;
  logic [8:0] ball_y_in;
  logic [3:0] vel_x_in, vel_y_in;
  logic [4:0] my_score_in, your_score_in;
  logic       you_serve_in, you_serve_first_in;
  logic       send_new_message, ball_message_tx, miss_message_tx;
  logic       new_game_message_tx, new_game_ack_message_tx;
  logic [8:0] ball_y_tx;
  logic [3:0] velocity_x_tx, velocity_y_tx;
  logic [4:0] my_score_tx, your_score_tx;
  logic       you_should_serve_tx, you_serve_first_tx, link_ready, link_fail;
  logic [7:0] dropped_count;

  comm_tx_scheduler #(
    .RETRY_CYCLES(16),
    .MAX_RETRIES (2),
    .DROP_W      (8)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .ball_req               (ball_req),
    .ball_y_in              (ball_y_in),
    .vel_x_in               (vel_x_in),
    .vel_y_in               (vel_y_in),
    .miss_req               (miss_req),
    .my_score_in            (my_score_in),
    .your_score_in          (your_score_in),
    .you_serve_in           (you_serve_in),
    .new_game_req           (new_game_req),
    .you_serve_first_in     (you_serve_first_in),
    .new_game_ack_req       (new_game_ack_req),
    .new_game_ack_rx        (new_game_ack_rx),
    .message_sent           (message_sent),
    .send_new_message       (send_new_message),
    .ball_message_tx        (ball_message_tx),
    .miss_message_tx        (miss_message_tx),
    .new_game_message_tx    (new_game_message_tx),
    .new_game_ack_message_tx(new_game_ack_message_tx),
    .ball_y_tx              (ball_y_tx),
    .velocity_x_tx          (velocity_x_tx),
    .velocity_y_tx          (velocity_y_tx),
    .my_score_tx            (my_score_tx),
    .your_score_tx          (your_score_tx),
    .you_should_serve_tx    (you_should_serve_tx),
    .you_serve_first_tx     (you_serve_first_tx),
    .link_ready             (link_ready),
    .link_fail              (link_fail),
    .dropped_count          (dropped_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] typ;
    logic [8:0] y;
    logic [3:0] vx;
    logic [3:0] vy;
    logic [4:0] my;
    logic [4:0] your;
    logic       ys;
    logic       ysf;
  } msg_t;

  typedef struct {
    msg_t stim;
    msg_t exp;
  } vec_t;

  msg_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one request pulse (seen by exactly one rising edge).
  task automatic drive_req(input msg_t m);
    ball_y_in          = m.y;
    vel_x_in           = m.vx;
    vel_y_in           = m.vy;
    my_score_in        = m.my;
    your_score_in      = m.your;
    you_serve_in       = m.ys;
    you_serve_first_in = m.ysf;
    new_game_ack_req   = m.typ[3];
    new_game_req       = m.typ[2];
    miss_req           = m.typ[1];
    ball_req           = m.typ[0];
    step();
    new_game_ack_req = 1'b0;
    new_game_req     = 1'b0;
    miss_req         = 1'b0;
    ball_req         = 1'b0;
  endtask

  task automatic pulse_ack_rx();
    new_game_ack_rx = 1'b1;
    step();
    new_game_ack_rx = 1'b0;
  endtask

  function automatic msg_t mk(input logic [3:0] typ, input logic [8:0] y, input logic [3:0] vx,
                              input logic [3:0] vy, input logic [4:0] my, input logic [4:0] your,
                              input logic ys, input logic ysf);
    msg_t m;
    m.typ = typ; m.y = y; m.vx = vx; m.vy = vy; m.my = my; m.your = your; m.ys = ys; m.ysf = ysf;
    return m;
  endfunction

  // Wait for the next send, compare against the scoreboard head, then accept it.
  task automatic send_one(input int delay, output int t_start);
    msg_t e;
    int   n = 0;
    t_start = 0;
    while (!send_new_message && n < 60) begin
      step();
      n++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!send_new_message) begin
      chk("send_timeout", 32'd0, 32'd1);
      return;
    end
    t_start = cyc;
    chk("type_lines", {28'd0, new_game_ack_message_tx, new_game_message_tx, miss_message_tx,
        ball_message_tx}, {28'd0, e.typ});
    if (e.typ == TBall) begin
      chk("ball_y", 32'(ball_y_tx), 32'(e.y));
      chk("vel_x", 32'(velocity_x_tx), 32'(e.vx));
      chk("vel_y", 32'(velocity_y_tx), 32'(e.vy));
    end else if (e.typ == TMiss) begin
      chk("my_score", 32'(my_score_tx), 32'(e.my));
      chk("your_score", 32'(your_score_tx), 32'(e.your));
      chk("you_serve", 32'(you_should_serve_tx), 32'(e.ys));
    end else if (e.typ == TNg) begin
      chk("you_serve_first", 32'(you_serve_first_tx), 32'(e.ysf));
    end
    for (int i = 0; i < delay; i++) begin
      step();
      chk("send_held", 32'(send_new_message), 32'd1);
    end
    message_sent = 1'b1;
    step();
    message_sent = 1'b0;
    chk("send_dropped", 32'(send_new_message), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, n, t0, t1, t2;
    logic seen;
    msg_t ng0, ng1;

    ng0 = mk(TNg, 0, 0, 0, 0, 0, 0, 1'b0);
    ng1 = mk(TNg, 0, 0, 0, 0, 0, 0, 1'b1);
    vecs[0] = '{mk(TBall, 9'd17, 4'd5, 4'b1111, 0, 0, 0, 0), mk(TBall, 9'd17, 4'd5, 4'hF, 0, 0, 0, 0)};
    vecs[1] = '{mk(TMiss, 0, 0, 0, 5'd31, 5'd0, 1'b1, 0), mk(TMiss, 0, 0, 0, 5'd31, 5'd0, 1'b1, 0)};
    vecs[2] = '{mk(TAck, 0, 0, 0, 0, 0, 0, 0), mk(TAck, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{mk(TBall, 9'd511, 4'd15, 4'd7, 0, 0, 0, 0), mk(TBall, 9'h1FF, 4'hF, 4'h7, 0, 0, 0, 0)};
    vecs[4] = '{mk(TMiss, 0, 0, 0, 5'd9, 5'd12, 1'b0, 0), mk(TMiss, 0, 0, 0, 5'd9, 5'd12, 1'b0, 0)};

    reset = 1'b1;
    {ball_req, miss_req, new_game_req, new_game_ack_req, new_game_ack_rx, message_sent} = '0;
    ball_y_in = '0; vel_x_in = '0; vel_y_in = '0; my_score_in = '0; your_score_in = '0;
    you_serve_in = 1'b0; you_serve_first_in = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_send", 32'(send_new_message), 32'd0);
    chk("rst_types", {28'd0, new_game_ack_message_tx, new_game_message_tx, miss_message_tx,
        ball_message_tx}, 32'd0);
    chk("rst_payload", {ball_y_tx, velocity_x_tx, velocity_y_tx, my_score_tx, your_score_tx,
        you_should_serve_tx, you_serve_first_tx}, 32'd0);
    chk("rst_link", {30'd0, link_ready, link_fail}, 32'd0);
    chk("rst_dropped", 32'(dropped_count), 32'd0);
    reset = 1'b0;
    step();

    // Bring-up with latency check
    exp_q.push_back(ng1);
    drive_req(ng1);
    chk("latency_n1", 32'(send_new_message), 32'd0);
    step();
    chk("latency_n2", 32'(send_new_message), 32'd1);
    send_one(1, t);
    chk("await_not_ready", 32'(link_ready), 32'd0);
    step();
    pulse_ack_rx();
    chk("link_up", 32'(link_ready), 32'd1);

    // Gating: ball and miss held back while the link is down
    exp_q.push_back(ng0);
    drive_req(ng0);
    send_one(0, t);
    chk("gate_link_down", 32'(link_ready), 32'd0);
    exp_q.push_back(mk(TMiss, 0, 0, 0, 5'd4, 5'd7, 1'b0, 0));
    exp_q.push_back(mk(TBall, 9'd200, 4'd3, 4'b1110, 0, 0, 0, 0));
    ball_y_in = 9'd200; vel_x_in = 4'd3; vel_y_in = 4'b1110;
    drive_req(mk(TMiss | TBall, 9'd200, 4'd3, 4'b1110, 5'd4, 5'd7, 1'b0, 0));
    seen = 1'b0;
    repeat (5) begin
      seen |= send_new_message;
      step();
    end
    chk("gate_no_send", 32'(seen), 32'd0);
    pulse_ack_rx();
    send_one(0, t);
    send_one(0, t);

    // Vector table with link up
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      drive_req(vecs[i].stim);
      send_one(i % 3, t);
    end

    // Overwrite while SEND is held
    exp_q.push_back(mk(TMiss, 0, 0, 0, 5'd1, 5'd2, 1'b1, 0));
    drive_req(mk(TMiss, 0, 0, 0, 5'd1, 5'd2, 1'b1, 0));
    step();
    chk("ovw_in_send", 32'(send_new_message), 32'd1);
    drive_req(mk(TBall, 9'd10, 4'd1, 4'd1, 0, 0, 0, 0));
    drive_req(mk(TBall, 9'd20, 4'd2, 4'd2, 0, 0, 0, 0));
    drive_req(mk(TBall, 9'd30, 4'd6, 4'b1001, 0, 0, 0, 0));
    exp_q.push_back(mk(TBall, 9'd30, 4'd6, 4'b1001, 0, 0, 0, 0));
    chk("ovw_dropped", 32'(dropped_count), 32'd2);
    send_one(0, t);
    send_one(0, t);

    // Ack sent from AWAIT_ACK returns there; retry timer keeps its progress
    exp_q.push_back(ng0);
    drive_req(ng0);
    send_one(0, t);
    repeat (5) step();
    exp_q.push_back(mk(TAck, 0, 0, 0, 0, 0, 0, 0));
    drive_req(mk(TAck, 0, 0, 0, 0, 0, 0, 0));
    send_one(0, t);
    n = 0;
    while (!send_new_message && n < 40) begin
      step();
      n++;
    end
    chk("timer_continued", 32'(n > 0 && n < 16), 32'd1);
    exp_q.push_back(ng0);
    send_one(0, t);
    pulse_ack_rx();
    chk("cross_link_up", 32'(link_ready), 32'd1);

    // Retry and fail: three new-game sends, then link_fail
    repeat (3) exp_q.push_back(ng1);
    drive_req(ng1);
    send_one(0, t0);
    send_one(0, t1);
    send_one(0, t2);
    chk("retry_gap1", 32'(t1 - t0 >= 16), 32'd1);
    chk("retry_gap2", 32'(t2 - t1 >= 16), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!link_fail && n < 40) begin
      seen |= send_new_message;
      step();
      n++;
    end
    chk("link_fail", 32'(link_fail), 32'd1);
    chk("no_fourth_send", 32'(seen), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      seen |= send_new_message;
      step();
    end
    chk("fail_idle", {30'd0, seen, link_ready}, 32'd0);

    // Async reset mid-SEND
    exp_q.push_back(ng0);
    drive_req(ng0);
    send_one(0, t);
    pulse_ack_rx();
    drive_req(mk(TBall, 9'd99, 4'd4, 4'd4, 0, 0, 0, 0));
    step();
    chk("pre_reset_send", 32'(send_new_message), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_drops_send", {27'd0, send_new_message, new_game_ack_message_tx,
        new_game_message_tx, miss_message_tx, ball_message_tx}, 32'd0);
    chk("reset_link", 32'(link_ready), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= send_new_message;
    end
    chk("no_reissue", 32'(seen), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comm_tx_scheduler.md
Name: comm_tx_scheduler

Overview:
- Arbitrates the four outgoing link message types (new-game ack, new-game, miss, ball) from the game-state logic.
- Sequences them one at a time into the serial sender over the send_new_message / message_sent handshake.
- Owns link bring-up: retransmits new-game until the peer acknowledges, and blocks ball and miss traffic until the link is up.
- Sits between the game-state module and CommunicationSender; CommunicationReceiver supplies the peer-ack indication.

Parameters:
RETRY_CYCLES, 5000000, cycles in AWAIT_ACK before new-game is resent (100 ms at 50 MHz)
MAX_RETRIES, 10, number of resends before link_fail is declared
DROP_W, 8, width of the saturating dropped-ball counter

Ports:
CLOCK_50  in  1  clock
reset  in  1  async active-high reset
ball_req  in  1  one-cycle pulse: queue a ball message
ball_y_in  in  9  ball row
vel_x_in  in  4  x velocity, unsigned
vel_y_in  in  4  y velocity, two's complement
miss_req  in  1  pulse: queue a miss message
my_score_in  in  5  local score
your_score_in  in  5  peer score
you_serve_in  in  1  peer serves next
new_game_req  in  1  pulse: queue a new-game message
you_serve_first_in  in  1  new-game payload
new_game_ack_req  in  1  pulse: queue an ack of a peer new-game
new_game_ack_rx  in  1  pulse: peer acknowledged our new-game
message_sent  in  1  sender accepted the current message
send_new_message  out  1  request to sender
ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx  out  1 each  type select
ball_y_tx  out  9  payload
velocity_x_tx  out  4  payload
velocity_y_tx  out  4  payload
my_score_tx  out  5  payload
your_score_tx  out  5  payload
you_should_serve_tx  out  1  payload
you_serve_first_tx  out  1  payload
link_ready  out  1  peer acked our last new-game
link_fail  out  1  retries exhausted
dropped_count  out  DROP_W  ball requests overwritten while pending (saturating)

Behaviour:
- Reset (asynchronous) state and outputs:
  - state = IDLE; all pending slots, retry counter and timer cleared.
  - All outputs 0, including all payload outputs, link_ready and dropped_count.
- Pending slots: one per type, each a valid bit plus payload.
  - A request sets valid and captures the payload on the clock edge.
  - A repeat request to a valid slot overwrites its payload.
  - A ball overwrite increments dropped_count; it saturates at all-ones.
  - If a request and the grant of the same slot occur on one edge, set wins and the new payload is kept.
- Priority, highest first: new_game_ack > new_game > miss > ball.
  - ball and miss are grantable only when link_ready = 1.
- new_game_req side effects:
  - Clears link_ready, link_fail, the retry counter, and the ball and miss slots. dropped_count is not incremented.
  - If the FSM is in AWAIT_ACK it returns to IDLE; the new new-game is then granted normally.
- Grant: on the edge where IDLE (or AWAIT_ACK, ack only) selects a slot:
  - The payload is copied into the output registers, the slot is cleared, and the FSM goes to SEND.
  - Latency: a request pulse in cycle n gives send_new_message high in cycle n+2 when idle.
- Output timing:
  - Exactly one type line is high, and only while send_new_message is high.
  - Payload outputs are stable throughout SEND and hold their last value afterwards.
- FSM:
  - IDLE: grant the highest eligible slot, else stay.
  - SEND: hold send_new_message = 1. On an edge with message_sent = 1, drop send_new_message on that edge, then:
    - new_game sent → AWAIT_ACK; timer cleared.
    - ack sent from AWAIT_ACK → AWAIT_ACK; timer is not cleared and keeps counting.
    - otherwise → IDLE.
  - AWAIT_ACK:
    - new_game_ack_rx = 1 → link_ready = 1, IDLE. This has priority over the other actions on the same edge.
    - Else if the ack slot is valid → grant it (SEND).
    - Else if timer = RETRY_CYCLES-1 and retries < MAX_RETRIES → retries++, resend the stored new-game payload (SEND).
    - Else if timer = RETRY_CYCLES-1 and retries = MAX_RETRIES → link_fail = 1, IDLE.
    - Else timer++.
- new_game_ack_rx outside AWAIT_ACK is ignored.
- message_sent outside SEND is ignored.
- A reset during any state aborts immediately; no partial message is reissued.

Test Plan:
- Bring-up:
  - Stimulus: reset, then new_game_req with you_serve_first_in = 1; sender returns message_sent 3 cycles after the request; then new_game_ack_rx pulse.
  - Response: send_new_message high at cycle 2 with new_game_message_tx = 1 and you_serve_first_tx = 1. FSM in AWAIT_ACK, then link_ready = 1.
- Gating and priority:
  - Stimulus: link_ready = 0, then ball_req (ball_y_in = 200, vel_x_in = 3, vel_y_in = -2) in the same cycle as miss_req (scores 4, 7).
  - Response: no send until link up. After link up, miss is sent first (my_score_tx = 4, your_score_tx = 7), then ball (ball_y_tx = 200, velocity_y_tx = 4'b1110).
- Overwrite:
  - Stimulus: three ball_req pulses with y = 10, 20, 30 while SEND is held (message_sent low).
  - Response: the next ball send carries y = 30; dropped_count = 2.
- Retry and fail:
  - Stimulus: RETRY_CYCLES = 16, MAX_RETRIES = 2, no new_game_ack_rx.
  - Response: exactly 3 new-game sends spaced ≥16 cycles apart, then link_fail = 1 and IDLE.
- Cross reset:
  - Stimulus: in AWAIT_ACK, new_game_ack_req arrives.
  - Response: the ack is sent, the FSM returns to AWAIT_ACK, and the timer continues without restarting.
- Async reset:
  - Stimulus: assert reset mid-SEND.
  - Response: send_new_message and all type lines drop immediately; no send occurs after release until a new request arrives.
